// File: rtl/rl_pi_pkg.sv
// Shared types and helpers for the rl_pi_ctrl discrete PI current controller.
// Holds the sequencer state enum, the Q-format constant, widths and the signed saturation helper.
package rl_pi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_PTERM,
    S_ITERM,
    S_SUM,
    S_CLAMP,
    S_DONE
  } state_t;

  localparam int FRAC      = 8;
  localparam int GAIN_W    = 16;
  localparam int SAT_W     = 64;
  localparam int W_DEF     = 32;
  localparam int INT_W_DEF = 48;

  // Clamp x to out_w-bit signed range; sym=1 gives +/-(2^(out_w-1)-1), sym=0 the full range.
  function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W:0] x,
                                                         input int out_w,
                                                         input logic sym);
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    hi = ((SAT_W+1)'(1) <<< (out_w - 1)) - (SAT_W+1)'(1);
    lo = sym ? -hi : -hi - (SAT_W+1)'(1);
    if (x > hi) begin
      return SAT_W'(hi);
    end else if (x < lo) begin
      return SAT_W'(lo);
    end
    return SAT_W'(x);
  endfunction

endpackage

// File: rtl/rl_pi_sat_add.sv
// Signed saturating adder/subtractor: result computed one bit wider, then clamped to WIDTH bits.
// SYM selects the symmetric clamp range used by the integrator.
module rl_pi_sat_add
  import rl_pi_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter bit SUB   = 1'b0,
  parameter bit SYM   = 1'b0
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH-1:0] y_o
);

  logic signed [WIDTH:0] full;

  always_comb begin
    if (SUB) begin
      full = (WIDTH+1)'(a_i) - (WIDTH+1)'(b_i);
    end else begin
      full = (WIDTH+1)'(a_i) + (WIDTH+1)'(b_i);
    end
    y_o = WIDTH'(sat_signed((SAT_W+1)'(full), WIDTH, SYM));
  end

endmodule

// File: rtl/rl_pi_ctrl.sv
// Discrete PI current controller: i_ref/i_meas -> voltage command u_cmd, one sample per 7 cycles.
// Define RL_PI_ANTI_WINDUP_EN to freeze the integrator while the output pushes deeper into its clamp.
module rl_pi_ctrl
  import rl_pi_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int KP    = 256,
  parameter int KI    = 13,
  parameter int INT_W = INT_W_DEF,
  parameter int U_MAX = 200,
  parameter int U_MIN = -200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                meas_valid,
  input  logic signed [W-1:0] i_meas,
  input  logic signed [W-1:0] i_ref,
  output logic                busy,
  output logic                u_valid,
  output logic signed [W-1:0] u_cmd,
  output logic                sat,
  output logic signed [W-1:0] err_out
);

  localparam logic signed [INT_W:0] UMAX_EXT = (INT_W+1)'(U_MAX);
  localparam logic signed [INT_W:0] UMIN_EXT = (INT_W+1)'(U_MIN);

  state_t state_q, state_d;

  logic signed [W-1:0]     meas_q, ref_q, err_q, err_d;
  logic signed [INT_W-1:0] p_q, integ_q, integ_nxt_q, integ_add;
  logic signed [INT_W-1:0] e_ext, k_ext, prod;
  logic signed [INT_W:0]   sum_full, sum_d, sum_q;
  logic signed [W-1:0]     u_cmd_q;
  logic                    sat_q, u_valid_q;
  logic [GAIN_W-1:0]       k_sel;
`ifdef RL_PI_ANTI_WINDUP_EN
  logic                    hold_q;
`endif

  rl_pi_sat_add #(.WIDTH(W), .SUB(1'b1), .SYM(1'b0)) u_err_sub (
    .a_i(ref_q),
    .b_i(meas_q),
    .y_o(err_d)
  );

  rl_pi_sat_add #(.WIDTH(INT_W), .SUB(1'b0), .SYM(1'b1)) u_integ_add (
    .a_i(integ_q),
    .b_i(prod),
    .y_o(integ_add)
  );

  // Single multiplier shared by PTERM and ITERM; INT_W >= W+GAIN_W keeps the product exact.
  always_comb begin
    k_sel    = (state_q == S_PTERM) ? GAIN_W'(KP) : GAIN_W'(KI);
    e_ext    = INT_W'(err_q);
    k_ext    = INT_W'($signed({1'b0, k_sel}));
    prod     = e_ext * k_ext;
    sum_full = (INT_W+1)'(p_q) + (INT_W+1)'(integ_nxt_q);
    sum_d    = sum_full >>> FRAC;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (meas_valid) state_d = S_ERR;
      S_ERR:   state_d = S_PTERM;
      S_PTERM: state_d = S_ITERM;
      S_ITERM: state_d = S_SUM;
      S_SUM:   state_d = S_CLAMP;
      S_CLAMP: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas_q      <= '0;
      ref_q       <= '0;
      err_q       <= '0;
      p_q         <= '0;
      integ_q     <= '0;
      integ_nxt_q <= '0;
      sum_q       <= '0;
      u_cmd_q     <= '0;
      sat_q       <= 1'b0;
      u_valid_q   <= 1'b0;
`ifdef RL_PI_ANTI_WINDUP_EN
      hold_q      <= 1'b0;
`endif
    end else begin
      u_valid_q <= (state_q == S_CLAMP);
      case (state_q)
        S_IDLE: begin
          if (meas_valid) begin
            meas_q <= i_meas;
            ref_q  <= i_ref;
          end
        end
        S_ERR:   err_q       <= err_d;
        S_PTERM: p_q         <= prod;
        S_ITERM: integ_nxt_q <= integ_add;
        S_SUM:   sum_q       <= sum_d;
        S_CLAMP: begin
          if (sum_q > UMAX_EXT) begin
            u_cmd_q <= W'(U_MAX);
            sat_q   <= 1'b1;
          end else if (sum_q < UMIN_EXT) begin
            u_cmd_q <= W'(U_MIN);
            sat_q   <= 1'b1;
          end else begin
            u_cmd_q <= W'(sum_q);
            sat_q   <= 1'b0;
          end
`ifdef RL_PI_ANTI_WINDUP_EN
          hold_q <= ((sum_q > UMAX_EXT) && (err_q > 0)) ||
                    ((sum_q < UMIN_EXT) && (err_q < 0));
`endif
        end
        S_DONE: begin
`ifdef RL_PI_ANTI_WINDUP_EN
          if (!hold_q) integ_q <= integ_nxt_q;
`else
          integ_q <= integ_nxt_q;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign u_valid = u_valid_q;
  assign u_cmd   = u_cmd_q;
  assign sat     = sat_q;
  assign err_out = err_q;

endmodule

// File: tb/tb_rl_pi_ctrl.sv
// Self-checking bench for rl_pi_ctrl: constant vector table, multi-cycle corner sequences,
// and randomized samples against an arithmetic reference model (honours RL_PI_ANTI_WINDUP_EN).
module tb_rl_pi_ctrl;

  localparam int W     = 32;
  localparam int KP    = 256;
  localparam int KI    = 13;
  localparam int INT_W = 48;
  localparam int U_MAX = 200;
  localparam int U_MIN = -200;

  localparam longint EMAX = (64'sd1 <<< 31) - 1;
  localparam longint EMIN = -(64'sd1 <<< 31);
  localparam longint IMAX = (64'sd1 <<< 47) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                meas_valid = 1'b0;
  logic signed [W-1:0] i_meas = '0;
  logic signed [W-1:0] i_ref = '0;
  logic                busy;
  logic                u_valid;
  logic signed [W-1:0] u_cmd;
  logic                sat;
  logic signed [W-1:0] err_out;

  rl_pi_ctrl #(
    .W(W), .KP(KP), .KI(KI), .INT_W(INT_W), .U_MAX(U_MAX), .U_MIN(U_MIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .meas_valid(meas_valid),
    .i_meas(i_meas),
    .i_ref(i_ref),
    .busy(busy),
    .u_valid(u_valid),
    .u_cmd(u_cmd),
    .sat(sat),
    .err_out(err_out)
  );

  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  longint model_integ = 0;

  typedef struct {
    longint r;
    longint m;
    longint u;
    longint s;
    longint e;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: error, PI terms and clamps straight from the controller's arithmetic rules.
  function automatic void model_step(input longint r, input longint m,
                                     output longint e, output longint u, output longint s);
    longint d, p, nx, sm;
    d  = r - m;
    e  = (d > EMAX) ? EMAX : ((d < EMIN) ? EMIN : d);
    p  = KP * e;
    nx = model_integ + KI * e;
    if (nx > IMAX) nx = IMAX;
    if (nx < -IMAX) nx = -IMAX;
    sm = (p + nx) >>> 8;
    if (sm > U_MAX) begin
      u = U_MAX; s = 1;
    end else if (sm < U_MIN) begin
      u = U_MIN; s = 1;
    end else begin
      u = sm; s = 0;
    end
`ifdef RL_PI_ANTI_WINDUP_EN
    if (!(s == 1 && ((u == U_MAX && e > 0) || (u == U_MIN && e < 0)))) model_integ = nx;
`else
    model_integ = nx;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    meas_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_integ = 0;
  endtask

  // Strobe one sample, wait (bounded) for u_valid, check latency and pulse shape.
  task automatic run_sample(input longint r, input longint m,
                            output longint u, output longint s, output longint e);
    longint lat;
    i_ref      = W'(r);
    i_meas     = W'(m);
    meas_valid = 1'b1;
    lat        = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) meas_valid = 1'b0;
      if (u_valid) begin
        lat = k;
        break;
      end
    end
    u = longint'(u_cmd);
    s = longint'(sat);
    e = longint'(err_out);
    $display("sample ref=%0d meas=%0d -> u_cmd=%0d sat=%0d err=%0d latency=%0d", r, m, u, s, e, lat);
    check("latency", lat, 6);
    if (lat > 0) begin
      check("busy_done", longint'(busy), 1);
      @(posedge clk);
      #1;
      check("pulse_width", longint'(u_valid), 0);
      check("busy_idle", longint'(busy), 0);
    end
  endtask

  initial begin
    longint u, s, e, mu, ms, me, r, m, ucap;
    int     pulses, busy_bad;

    vecs[0]  = '{10, 0, 10, 0, 10};
    vecs[1]  = '{0, 5, -6, 0, -5};
    vecs[2]  = '{1000, 0, 200, 1, 1000};
    vecs[3]  = '{-1000, 0, -200, 1, -1000};
    vecs[4]  = '{1, 0, 1, 0, 1};
    vecs[5]  = '{-1, 0, -2, 0, -1};
    vecs[6]  = '{EMAX, -1, 200, 1, EMAX};
    vecs[7]  = '{EMIN, 1, -200, 1, EMIN};
    vecs[8]  = '{190, 0, 199, 0, 190};
    vecs[9]  = '{191, 0, 200, 0, 191};
    vecs[10] = '{0, 190, -200, 0, -190};
    vecs[11] = '{0, 191, -200, 1, -191};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy_held", longint'(busy), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_u_cmd", longint'(u_cmd), 0);
    check("rst_sat", longint'(sat), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_u_valid", longint'(u_valid), 0);
    check("rst_err_out", longint'(err_out), 0);

    // Table vectors, each from reset
    for (int i = 0; i < 12; i++) begin
      do_reset();
      run_sample(vecs[i].r, vecs[i].m, u, s, e);
      check($sformatf("vec%0d_u_cmd", i), u, vecs[i].u);
      check($sformatf("vec%0d_sat", i), s, vecs[i].s);
      check($sformatf("vec%0d_err", i), e, vecs[i].e);
    end

    // Saturation and windup
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_sample(1000, 0, u, s, e);
      check("windup_u_cmd", u, 200);
      check("windup_sat", s, 1);
    end
    run_sample(0, 0, u, s, e);
`ifdef RL_PI_ANTI_WINDUP_EN
    check("windup_release_u", u, 0);
`else
    check("windup_release_u", u, 152);
`endif
    check("windup_release_sat", s, 0);

    // Strobes during a sample in flight are ignored
    do_reset();
    i_ref = 10;
    i_meas = 0;
    meas_valid = 1'b1;
    pulses = 0;
    busy_bad = 0;
    ucap = -999;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (u_valid) begin
        pulses++;
        ucap = longint'(u_cmd);
      end
      if (busy !== (k <= 6)) busy_bad++;
      meas_valid = (k == 2 || k == 6);
      if (k == 2) i_ref = 50;
    end
    meas_valid = 1'b0;
    $display("ignored-strobe sample: pulses=%0d u_cmd=%0d", pulses, ucap);
    check("ignored_pulses", pulses, 1);
    check("ignored_busy_window", busy_bad, 0);
    check("ignored_u_cmd", ucap, 10);

    // Asynchronous reset in PTERM aborts the sample
    do_reset();
    i_ref = 10;
    i_meas = 0;
    meas_valid = 1'b1;
    @(posedge clk);
    #1 meas_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort_err_before", longint'(err_out), 10);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", longint'(busy), 0);
    check("abort_err_cleared", longint'(err_out), 0);
    check("abort_u_valid", longint'(u_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_integ = 0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (u_valid) pulses++;
    end
    $display("aborted sample: pulses=%0d", pulses);
    check("abort_no_pulse", pulses, 0);
    run_sample(0, 0, u, s, e);
    check("abort_next_u", u, 0);
    check("abort_next_sat", s, 0);

    // Randomized samples against the model
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        r = ($urandom_range(0, 1) == 1) ? EMAX : EMIN;
        m = longint'($urandom_range(0, 2000)) - 1000;
      end else begin
        r = longint'($urandom_range(0, 600)) - 300;
        m = longint'($urandom_range(0, 600)) - 300;
      end
      model_step(r, m, me, mu, ms);
      run_sample(r, m, u, s, e);
      check("rand_u_cmd", u, mu);
      check("rand_sat", s, ms);
      check("rand_err", e, me);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
